dual_slope_ctrl: RTL and testbench



---
 rtl/dual_slope_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// Control FSM for a dual-slope integrating ADC: auto-zero, fixed-time
// integration, counted de-integration, then result latch and interrupt.
// Optional feature macro: DUAL_SLOPE_CTRL_AUTOZERO_EN (defined = AUTOZERO
// phase present; undefined = IDLE starts integration directly, zero_o = 0).
module dual_slope_ctrl #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned INT_CYCLES = 2048,
  parameter int unsigned AZ_CYCLES  = 16,
  parameter int unsigned SW_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             comp_i,
  input  logic             analog_ready_i,
  input  logic             trigger_i,
  input  logic             interrupt_clear_i,
  input  logic             deintegrate_i,
  output logic             interrupt_o,
  output logic             zero_o,
  output logic             int_en_o,
  output logic             deint_req_o,
  output logic [CNT_W-1:0] result_o,
  output logic             overflow_o,
  output logic             error_o,
  output logic             busy_o
);

  // One shared phase counter, wide enough for every phase length and the count
  localparam int unsigned MAX_CNT = (1 << CNT_W) - 1;
  localparam int unsigned INT_W   = $clog2(INT_CYCLES + 1);
  localparam int unsigned AZ_W    = $clog2(AZ_CYCLES + 1);
  localparam int unsigned SW_W    = $clog2(SW_TIMEOUT + 1);
  localparam int unsigned MAX_AB  = (INT_W > AZ_W) ? INT_W : AZ_W;
  localparam int unsigned MAX_ABC = (MAX_AB > SW_W) ? MAX_AB : SW_W;
  localparam int unsigned CW      = (MAX_ABC > CNT_W) ? MAX_ABC : CNT_W;

  localparam logic [2:0] IDLE      = 3'd0;
`ifdef DUAL_SLOPE_CTRL_AUTOZERO_EN
  localparam logic [2:0] AUTOZERO  = 3'd1;
  localparam logic [2:0] START_ST  = AUTOZERO;
`else
  localparam logic [2:0] START_ST  = 3'd2;
`endif
  localparam logic [2:0] INTEGRATE = 3'd2;
  localparam logic [2:0] SWITCH    = 3'd3;
  localparam logic [2:0] DEINT     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] result_nxt;
  logic             overflow_nxt, error_nxt, irq_nxt;
  logic             int_en_nxt, deint_req_nxt, busy_nxt;
  logic             comp_m, comp_s;
  logic             active;

  // Comparator synchronizer; every decision uses comp_s
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      comp_m <= 1'b0;
      comp_s <= 1'b0;
    end else begin
      comp_m <= comp_i;
      comp_s <= comp_m;
    end
  end

  // Next-state, counter, result and flag logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    result_nxt   = result_o;
    overflow_nxt = overflow_o;
    error_nxt    = error_o;
    irq_nxt      = interrupt_o;
    active       = (state != IDLE) && (state != DONE);

    if (interrupt_clear_i) irq_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (trigger_i && analog_ready_i && !interrupt_o) begin
          state_nxt    = START_ST;
          cnt_nxt      = '0;
          overflow_nxt = 1'b0;
          error_nxt    = 1'b0;
        end
      end
`ifdef DUAL_SLOPE_CTRL_AUTOZERO_EN
      AUTOZERO: begin
        if (cnt == CW'(AZ_CYCLES - 1)) begin
          state_nxt = INTEGRATE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      INTEGRATE: begin
        if (cnt == CW'(INT_CYCLES - 1)) begin
          state_nxt = SWITCH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SWITCH: begin
        if (deintegrate_i) begin
          state_nxt = DEINT;
          cnt_nxt   = '0;
        end else if (cnt == CW'(SW_TIMEOUT - 1)) begin
          state_nxt  = DONE;
          cnt_nxt    = '0;
          error_nxt  = 1'b1;
          result_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DEINT: begin
        if (!comp_s) begin
          state_nxt  = DONE;
          result_nxt = cnt[CNT_W-1:0];
          cnt_nxt    = '0;
        end else if (cnt == CW'(MAX_CNT - 1)) begin
          state_nxt    = DONE;
          result_nxt   = {CNT_W{1'b1}};
          overflow_nxt = 1'b1;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Losing the analog front end abandons the conversion without a result
    if (active && !analog_ready_i) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      error_nxt    = 1'b1;
      result_nxt   = result_o;
      overflow_nxt = overflow_o;
    end

    int_en_nxt    = (state_nxt == INTEGRATE);
    deint_req_nxt = (state_nxt == SWITCH) || (state_nxt == DEINT);
    busy_nxt      = (state_nxt != IDLE);
  end

  // State and registered outputs; reset drops every enable immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      error_o     <= 1'b0;
      interrupt_o <= 1'b0;
      int_en_o    <= 1'b0;
      deint_req_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      result_o    <= result_nxt;
      overflow_o  <= overflow_nxt;
      error_o     <= error_nxt;
      interrupt_o <= irq_nxt;
      int_en_o    <= int_en_nxt;
      deint_req_o <= deint_req_nxt;
      busy_o      <= busy_nxt;
    end
  end

`ifdef DUAL_SLOPE_CTRL_AUTOZERO_EN
  // Auto-zero switch enable, aligned with the AUTOZERO state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) zero_o <= 1'b0;
    else       zero_o <= (state_nxt == AUTOZERO);
  end
`else
  assign zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl (CNT_W=6, INT_CYCLES=8, AZ_CYCLES=2,
// SW_TIMEOUT=4); adapts to DUAL_SLOPE_CTRL_AUTOZERO_EN being defined or not.
module tb_dual_slope_ctrl;

  localparam int unsigned CNT_W = 6;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             comp_i;
  logic             analog_ready_i;
  logic             trigger_i;
  logic             interrupt_clear_i;
  logic             deintegrate_i;
  logic             interrupt_o;
  logic             zero_o;
  logic             int_en_o;
  logic             deint_req_o;
  logic [CNT_W-1:0] result_o;
  logic             overflow_o;
  logic             error_o;
  logic             busy_o;

  int vectors     = 0;
  int miscompares = 0;

  dual_slope_ctrl #(
    .CNT_W(6), .INT_CYCLES(8), .AZ_CYCLES(2), .SW_TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .comp_i(comp_i),
    .analog_ready_i(analog_ready_i), .trigger_i(trigger_i),
    .interrupt_clear_i(interrupt_clear_i), .deintegrate_i(deintegrate_i),
    .interrupt_o(interrupt_o), .zero_o(zero_o), .int_en_o(int_en_o),
    .deint_req_o(deint_req_o), .result_o(result_o), .overflow_o(overflow_o),
    .error_o(error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trigger a conversion and follow it up to the first SWITCH cycle
  task automatic start_conv();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    check("start_busy", 32'(busy_o), 1);
    check("start_ovf_clr", 32'(overflow_o), 0);
    check("start_err_clr", 32'(error_o), 0);
`ifdef DUAL_SLOPE_CTRL_AUTOZERO_EN
    check("az_cycle1", 32'(zero_o), 1);
    tick();
    check("az_cycle2", 32'(zero_o), 1);
    tick();
`endif
    check("az_off", 32'(zero_o), 0);
    check("int_first", 32'(int_en_o), 1);
    repeat (7) begin
      tick();
      check("int_on", 32'(int_en_o), 1);
    end
    tick();
    check("int_off", 32'(int_en_o), 0);
    check("sw_req", 32'(deint_req_o), 1);
  endtask

  initial begin
    rst_i = 1'b1;
    comp_i = 1'b0;
    analog_ready_i = 1'b0;
    trigger_i = 1'b0;
    interrupt_clear_i = 1'b0;
    deintegrate_i = 1'b0;
    #2;
    check("rst_irq", 32'(interrupt_o), 0);
    check("rst_zero", 32'(zero_o), 0);
    check("rst_int", 32'(int_en_o), 0);
    check("rst_dreq", 32'(deint_req_o), 0);
    check("rst_result", 32'(result_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    tick();
    rst_i = 1'b0;
    analog_ready_i = 1'b1;
    tick();
    tick();

    // Nominal: comp_s high for 10 DEINT cycles -> result 10
    comp_i = 1'b1;
    start_conv();
    deintegrate_i = 1'b1;
    tick();
    deintegrate_i = 1'b0;
    check("nom_deint_req", 32'(deint_req_o), 1);
    trigger_i = 1'b1;                 // ignored while busy
    repeat (8) tick();
    trigger_i = 1'b0;
    comp_i = 1'b0;
    tick();
    tick();
    check("nom_still_deint", 32'(deint_req_o), 1);
    tick();
    check("nom_result", 32'(result_o), 10);
    check("nom_done_dreq", 32'(deint_req_o), 0);
    check("nom_done_irq", 32'(interrupt_o), 0);
    interrupt_clear_i = 1'b1;         // collides with interrupt set
    tick();
    interrupt_clear_i = 1'b0;
    check("collide_irq", 32'(interrupt_o), 1);
    check("nom_idle", 32'(busy_o), 0);
    check("nom_ovf", 32'(overflow_o), 0);
    check("nom_err", 32'(error_o), 0);

    // Trigger while interrupt pending is ignored
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    check("gate_irq_busy", 32'(busy_o), 0);
    check("gate_irq_result", 32'(result_o), 10);
    interrupt_clear_i = 1'b1;
    tick();
    interrupt_clear_i = 1'b0;
    check("clear_irq", 32'(interrupt_o), 0);

    // Trigger with front end not ready is ignored
    analog_ready_i = 1'b0;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    analog_ready_i = 1'b1;
    check("gate_rdy_busy", 32'(busy_o), 0);
    check("gate_rdy_zero", 32'(zero_o), 0);

    // Overflow: comparator never falls
    comp_i = 1'b1;
    start_conv();
    deintegrate_i = 1'b1;
    tick();
    deintegrate_i = 1'b0;
    repeat (62) tick();
    check("ovf_pre_dreq", 32'(deint_req_o), 1);
    check("ovf_pre_flag", 32'(overflow_o), 0);
    tick();
    check("ovf_result", 32'(result_o), 63);
    check("ovf_flag", 32'(overflow_o), 1);
    tick();
    check("ovf_irq", 32'(interrupt_o), 1);
    interrupt_clear_i = 1'b1;
    tick();
    interrupt_clear_i = 1'b0;
    check("ovf_clear", 32'(interrupt_o), 0);

    // Switch timeout: deintegrate_i never arrives
    start_conv();
    tick();
    tick();
    tick();
    check("to_pre_dreq", 32'(deint_req_o), 1);
    check("to_pre_err", 32'(error_o), 0);
    tick();
    check("to_err", 32'(error_o), 1);
    check("to_result", 32'(result_o), 0);
    check("to_dreq_off", 32'(deint_req_o), 0);
    tick();
    check("to_irq", 32'(interrupt_o), 1);
    interrupt_clear_i = 1'b1;
    tick();
    interrupt_clear_i = 1'b0;

    // Abort: analog_ready_i drops during INTEGRATE
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
`ifdef DUAL_SLOPE_CTRL_AUTOZERO_EN
    tick();
    tick();
`endif
    tick();
    check("ab_in_int", 32'(int_en_o), 1);
    analog_ready_i = 1'b0;
    tick();
    check("ab_idle", 32'(busy_o), 0);
    check("ab_int_off", 32'(int_en_o), 0);
    check("ab_err", 32'(error_o), 1);
    check("ab_result", 32'(result_o), 0);
    tick();
    check("ab_no_irq", 32'(interrupt_o), 0);
    analog_ready_i = 1'b1;
    tick();

    // Reset in the middle of DEINT clears outputs without a clock edge
    comp_i = 1'b1;
    start_conv();
    deintegrate_i = 1'b1;
    tick();
    deintegrate_i = 1'b0;
    tick();
    tick();
    check("rmid_dreq", 32'(deint_req_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rmid_dreq_off", 32'(deint_req_o), 0);
    check("rmid_busy", 32'(busy_o), 0);
    check("rmid_err", 32'(error_o), 0);
    check("rmid_result", 32'(result_o), 0);
    check("rmid_irq", 32'(interrupt_o), 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
